// File: rtl/spi_flash_pkg.sv
// Shared definitions for the AHB-Lite SPI flash reader: command code, HTRANS codes, FSM states.
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ = 8'h03;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_SHIFT,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_e;

    // Flash bytes arrive first-byte-in-MSB; the bus word is little-endian.
    function automatic logic [31:0] swap_bytes(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_bit_engine.sv
// Mode-0 SPI shifter: sends {READ, addr} MSB first, then clocks in 32 data bits.
module spi_bit_engine
    import spi_flash_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [23:0] i_addr,
    input  logic        i_miso,
    output logic        o_busy,
    output logic        o_last,
    output logic        o_sck,
    output logic        o_mosi,
    output logic [31:0] o_rdata
);

    localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

    logic        r_busy;
    logic        r_sck;
    logic [7:0]  r_div;
    logic [5:0]  r_bit;
    logic [31:0] r_tx;
    logic [31:0] r_rx;
    logic        w_div_end;

    assign w_div_end = (r_div == DIV_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= 1'b0;
            r_sck  <= 1'b0;
            r_div  <= 8'd0;
            r_bit  <= 6'd0;
            r_tx   <= 32'd0;
            r_rx   <= 32'd0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_sck  <= 1'b0;
            r_div  <= 8'd0;
            r_bit  <= 6'd0;
            r_tx   <= {CMD_READ, i_addr};
        end else if (r_busy) begin
            if (w_div_end) begin
                r_div <= 8'd0;
                if (!r_sck) begin
                    r_sck <= 1'b1;
                    r_rx  <= {r_rx[30:0], i_miso};
                end else begin
                    // Zero fill keeps MOSI low once the command/address has gone out.
                    r_sck <= 1'b0;
                    r_tx  <= {r_tx[30:0], 1'b0};
                    r_bit <= r_bit + 6'd1;
                    if (r_bit == 6'd63) begin
                        r_busy <= 1'b0;
                    end
                end
            end else begin
                r_div <= r_div + 8'd1;
            end
        end
    end

    assign o_busy  = r_busy;
    assign o_last  = r_busy & r_sck & w_div_end & (r_bit == 6'd63);
    assign o_sck   = r_sck;
    assign o_mosi  = r_tx[31];
    assign o_rdata = r_rx;

endmodule

// File: rtl/ahbl_spi_flash_reader.sv
// AHB-Lite instruction-fetch slave reading SPI NOR flash with a one-word fetch buffer.
module ahbl_spi_flash_reader
    import spi_flash_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 1,
    parameter int unsigned CS_GAP       = 2,
    parameter logic [23:0] FLASH_OFFSET = 24'h000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        ahbl_hsel_i,
    input  logic [31:0] ahbl_haddr_i,
    input  logic [1:0]  ahbl_htrans_i,
    input  logic        ahbl_hwrite_i,
    input  logic [2:0]  ahbl_hsize_i,
    input  logic        ahbl_hready_i,
    input  logic [31:0] ahbl_hwdata_i,
    output logic        ahbl_hreadyout_o,
    output logic        ahbl_hresp_o,
    output logic [31:0] ahbl_hrdata_o,
    output logic        spi_cs,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam logic [7:0] CS_GAP_W  = 8'(CS_GAP);
    localparam logic [7:0] CS_GAP_M1 = 8'(CS_GAP - 1);

    state_e      r_state;
    logic        r_hreadyout;
    logic        r_hresp;
    logic [31:0] r_hrdata;
    logic        r_spi_cs;
    logic [7:0]  r_cs_cnt;
    logic        r_buf_valid;
    logic [21:0] r_buf_tag;
    logic [31:0] r_buf_data;
    logic [21:0] r_tag;
    logic [23:0] r_faddr;

    logic        w_accept;
    logic        w_hit;
    logic        w_gap_ok;
    logic        w_start;
    logic [23:0] w_faddr;
    logic [23:0] w_start_addr;
    logic        w_eng_busy;
    logic        w_eng_last;
    logic [31:0] w_eng_rdata;
    logic [31:0] w_word;
    logic        w_unused;

    assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR2))
                      && ahbl_hsel_i && ahbl_hready_i && ahbl_htrans_i[1];
    assign w_hit    = r_buf_valid && (r_buf_tag == ahbl_haddr_i[23:2]);
    // r_cs_cnt holds high cycles before this one, so the current cycle counts as one more.
    assign w_gap_ok = r_spi_cs && (r_cs_cnt >= CS_GAP_M1);
    assign w_faddr  = {ahbl_haddr_i[23:2], 2'b00} + FLASH_OFFSET;

    assign w_start = (w_accept && !ahbl_hwrite_i && !w_hit && w_gap_ok)
                     || ((r_state == ST_GAP) && w_gap_ok);
    assign w_start_addr = (r_state == ST_GAP) ? r_faddr : w_faddr;
    assign w_word       = swap_bytes(w_eng_rdata);

    spi_bit_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_start (w_start),
        .i_addr  (w_start_addr),
        .i_miso  (spi_miso),
        .o_busy  (w_eng_busy),
        .o_last  (w_eng_last),
        .o_sck   (spi_clk),
        .o_mosi  (spi_mosi),
        .o_rdata (w_eng_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_hrdata    <= 32'd0;
            r_spi_cs    <= 1'b1;
            r_cs_cnt    <= CS_GAP_W;
            r_buf_valid <= 1'b0;
            r_buf_tag   <= 22'd0;
            r_buf_data  <= 32'd0;
            r_tag       <= 22'd0;
            r_faddr     <= 24'd0;
        end else begin
            if (!r_spi_cs) begin
                r_cs_cnt <= 8'd0;
            end else if (r_cs_cnt < CS_GAP_W) begin
                r_cs_cnt <= r_cs_cnt + 8'd1;
            end

            unique case (r_state)
                ST_IDLE, ST_DONE, ST_ERR2: begin
                    r_state     <= ST_IDLE;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b0;
                    r_spi_cs    <= 1'b1;
                    if (w_accept) begin
                        if (ahbl_hwrite_i) begin
                            r_state     <= ST_ERR1;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= 1'b1;
                        end else if (w_hit) begin
                            r_hrdata <= r_buf_data;
                        end else begin
                            r_tag       <= ahbl_haddr_i[23:2];
                            r_faddr     <= w_faddr;
                            r_hreadyout <= 1'b0;
                            if (w_gap_ok) begin
                                r_state  <= ST_SHIFT;
                                r_spi_cs <= 1'b0;
                            end else begin
                                r_state <= ST_GAP;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (w_gap_ok) begin
                        r_state  <= ST_SHIFT;
                        r_spi_cs <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (w_eng_last) begin
                        r_state     <= ST_DONE;
                        r_spi_cs    <= 1'b1;
                        r_hreadyout <= 1'b1;
                        r_hrdata    <= w_word;
                        r_buf_data  <= w_word;
                        r_buf_tag   <= r_tag;
                        r_buf_valid <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    r_state     <= ST_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Flush overrides a buffer load in the same cycle.
            if (flush_i) begin
                r_buf_valid <= 1'b0;
            end
        end
    end

    assign ahbl_hreadyout_o = r_hreadyout;
    assign ahbl_hresp_o     = r_hresp;
    assign ahbl_hrdata_o    = r_hrdata;
    assign spi_cs           = r_spi_cs;

    assign w_unused = ^{ahbl_haddr_i[31:24], ahbl_haddr_i[1:0], ahbl_htrans_i[0], ahbl_hsize_i,
                        ahbl_hwdata_i, w_eng_busy};

endmodule

// File: tb/tb_ahbl_spi_flash_reader.sv
// Directed bench: two reader instances (CLK_DIV=1 and CLK_DIV=3 with offset) on behavioural flash.
module tb_ahbl_spi_flash_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        hsel_a = 1'b0;
    logic        hsel_b = 1'b0;
    logic [31:0] haddr = 32'd0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;

    logic        rdy_a, resp_a, cs_a, sck_a, mosi_a;
    logic        rdy_b, resp_b, cs_b, sck_b, mosi_b;
    logic        miso_a = 1'b0;
    logic        miso_b = 1'b0;
    logic [31:0] rdata_a, rdata_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ahbl_spi_flash_reader #(
        .CLK_DIV      (1),
        .CS_GAP       (2),
        .FLASH_OFFSET (24'h000000)
    ) dut_a (
        .clk_i            (clk),
        .rst_i            (rst),
        .flush_i          (flush),
        .ahbl_hsel_i      (hsel_a),
        .ahbl_haddr_i     (haddr),
        .ahbl_htrans_i    (htrans),
        .ahbl_hwrite_i    (hwrite),
        .ahbl_hsize_i     (3'b010),
        .ahbl_hready_i    (rdy_a),
        .ahbl_hwdata_i    (32'hdead_beef),
        .ahbl_hreadyout_o (rdy_a),
        .ahbl_hresp_o     (resp_a),
        .ahbl_hrdata_o    (rdata_a),
        .spi_cs           (cs_a),
        .spi_clk          (sck_a),
        .spi_mosi         (mosi_a),
        .spi_miso         (miso_a)
    );

    ahbl_spi_flash_reader #(
        .CLK_DIV      (3),
        .CS_GAP       (2),
        .FLASH_OFFSET (24'h100000)
    ) dut_b (
        .clk_i            (clk),
        .rst_i            (rst),
        .flush_i          (flush),
        .ahbl_hsel_i      (hsel_b),
        .ahbl_haddr_i     (haddr),
        .ahbl_htrans_i    (htrans),
        .ahbl_hwrite_i    (hwrite),
        .ahbl_hsize_i     (3'b010),
        .ahbl_hready_i    (rdy_b),
        .ahbl_hwdata_i    (32'h0),
        .ahbl_hreadyout_o (rdy_b),
        .ahbl_hresp_o     (resp_b),
        .ahbl_hrdata_o    (rdata_b),
        .spi_cs           (cs_b),
        .spi_clk          (sck_b),
        .spi_mosi         (mosi_b),
        .spi_miso         (miso_b)
    );

    // Flash contents: byte 0x100 = 0x13, 0x101..0x103 = 0, everything else = low addr byte + 0x40.
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        if (a == 24'h000100) return 8'h13;
        if (a > 24'h000100 && a < 24'h000104) return 8'h00;
        return a[7:0] + 8'h40;
    endfunction

    // Flash model A
    int          bc_a = 0;
    int          cs_falls_a = 0;
    logic [31:0] cmd_a = 32'd0;
    logic        mosi_dat_a = 1'b0;
    int          hi_run_a = 0;
    int          last_hi_a = 0;

    always @(negedge cs_a) begin
        bc_a = 0;
        mosi_dat_a = 1'b0;
        cs_falls_a++;
    end
    always @(posedge sck_a) if (!cs_a) begin
        if (bc_a < 32) cmd_a = {cmd_a[30:0], mosi_a};
        else if (mosi_a) mosi_dat_a = 1'b1;
        bc_a++;
    end
    always @(negedge sck_a) if (!cs_a && bc_a >= 32 && bc_a < 64) begin
        logic [7:0] b;
        b = flash_byte(cmd_a[23:0] + 24'((bc_a - 32) / 8));
        miso_a = b[3'(7 - ((bc_a - 32) % 8))];
    end
    always @(negedge clk) begin
        if (cs_a) hi_run_a++;
        else begin
            if (hi_run_a != 0) last_hi_a = hi_run_a;
            hi_run_a = 0;
        end
    end

    // Flash model B
    int          bc_b = 0;
    logic [31:0] cmd_b = 32'd0;
    time         t_rise0 = 0;
    time         t_rise1 = 0;

    always @(negedge cs_b) bc_b = 0;
    always @(posedge sck_b) if (!cs_b) begin
        if (bc_b == 0) t_rise0 = $time;
        if (bc_b == 1) t_rise1 = $time;
        if (bc_b < 32) cmd_b = {cmd_b[30:0], mosi_b};
        bc_b++;
    end
    always @(negedge sck_b) if (!cs_b && bc_b >= 32 && bc_b < 64) begin
        logic [7:0] b;
        b = flash_byte(cmd_b[23:0] + 24'((bc_b - 32) / 8));
        miso_b = b[3'(7 - ((bc_b - 32) % 8))];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic addr_phase(input bit sel_b, input logic [31:0] a, input logic wr);
        hsel_a = !sel_b;
        hsel_b = sel_b;
        haddr  = a;
        htrans = 2'b10;
        hwrite = wr;
    endtask

    task automatic bus_idle();
        hsel_a = 1'b0;
        hsel_b = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
    endtask

    // Counts data-phase wait cycles; returns at the negedge of the ready cycle, -1 on timeout.
    task automatic wait_ready(input bit sel_b, output int waits);
        waits = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if ((sel_b ? rdy_b : rdy_a) === 1'b1) return;
            waits++;
        end
        waits = -1;
    endtask

    task automatic do_read(input bit sel_b, input logic [31:0] a, output int waits);
        @(posedge clk);
        #1 addr_phase(sel_b, a, 1'b0);
        @(posedge clk);
        #1 bus_idle();
        wait_ready(sel_b, waits);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int falls;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hreadyout", rdy_a, 1);
        chk("rst_hresp", resp_a, 0);
        chk("rst_hrdata", rdata_a, 0);
        chk("rst_cs_clk_mosi", {cs_a, sck_a, mosi_a, cs_b}, 4'b1001);
        rst = 1'b0;

        // Miss at 0x100
        do_read(1'b0, 32'h100, w);
        chk("miss100_waits", w, 128);
        chk("miss100_data", rdata_a, 32'h0000_0013);
        chk("miss100_resp", resp_a, 0);
        chk("miss100_cmd", cmd_a, 32'h0300_0100);
        chk("miss100_mosi_data_low", mosi_dat_a, 0);
        chk("miss100_done_pins", {cs_a, sck_a}, 2'b10);

        // Miss then hit at 0x104
        do_read(1'b0, 32'h104, w);
        chk("miss104_waits", w, 128);
        chk("miss104_data", rdata_a, 32'h4746_4544);
        falls = cs_falls_a;
        do_read(1'b0, 32'h104, w);
        chk("hit104_waits", w, 0);
        chk("hit104_data", rdata_a, 32'h4746_4544);
        chk("hit104_no_spi", cs_falls_a, falls);

        // 0x200 presented during miss to 0x108, accepted in its DONE cycle
        @(posedge clk);
        #1 addr_phase(1'b0, 32'h108, 1'b0);
        @(posedge clk);
        #1 addr_phase(1'b0, 32'h200, 1'b0);
        wait_ready(1'b0, w);
        chk("miss108_waits", w, 128);
        chk("miss108_data", rdata_a, 32'h4B4A_4948);
        @(posedge clk);
        #1 bus_idle();
        wait_ready(1'b0, w);
        chk("pipe200_waits", w, 129);
        chk("pipe200_data", rdata_a, 32'h4342_4140);
        chk("pipe200_cs_gap", last_hi_a, 2);
        chk("pipe200_cmd", cmd_a, 32'h0300_0200);

        // Write -> two-cycle ERROR
        falls = cs_falls_a;
        @(posedge clk);
        #1 addr_phase(1'b0, 32'h0, 1'b1);
        @(posedge clk);
        #1 bus_idle();
        @(negedge clk);
        chk("err1", {rdy_a, resp_a}, 2'b01);
        @(negedge clk);
        chk("err2", {rdy_a, resp_a}, 2'b11);
        @(negedge clk);
        chk("err_after", {rdy_a, resp_a}, 2'b10);
        chk("err_no_spi", cs_falls_a, falls);

        // Flush forces reissue
        do_read(1'b0, 32'h104, w);
        chk("refill104_waits", w, 128);
        falls = cs_falls_a;
        do_read(1'b0, 32'h104, w);
        chk("prefl_hit_waits", w, 0);
        chk("prefl_hit_no_spi", cs_falls_a, falls);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        do_read(1'b0, 32'h104, w);
        chk("flush_waits", w, 128);
        chk("flush_reissue", cs_falls_a, falls + 1);
        chk("flush_data", rdata_a, 32'h4746_4544);

        // Reset at SPI bit 20
        @(posedge clk);
        #1 addr_phase(1'b0, 32'h300, 1'b0);
        @(posedge clk);
        #1 bus_idle();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bc_a >= 20) break;
        end
        chk("rst_bit20_reached", 32'(bc_a >= 20), 1);
        chk("rst_bit20_in_shift", {cs_a, rdy_a}, 2'b00);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_pins", {cs_a, sck_a, mosi_a, rdy_a, resp_a}, 5'b10010);
        chk("rst_mid_hrdata", rdata_a, 0);
        do_read(1'b0, 32'h104, w);
        chk("post_rst_miss_waits", w, 128);
        chk("post_rst_data", rdata_a, 32'h4746_4544);

        // CLK_DIV=3, FLASH_OFFSET=0x100000
        do_read(1'b1, 32'h8, w);
        chk("div3_waits", w, 384);
        chk("div3_cmd", cmd_b, 32'h0310_0008);
        chk("div3_sck_period", 32'(t_rise1 - t_rise0), 60);
        chk("div3_data", rdata_b, 32'h4B4A_4948);
        chk("div3_resp", resp_b, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ahbl_spi_flash_reader.md
Name: ahbl_spi_flash_reader

Overview:
AHB-Lite slave that serves CPU instruction fetches (M0 INSTR bus) directly from external SPI NOR flash using the standard READ (0x03) command. It sits between the SoC interconnect and the spi_cs/spi_clk/spi_mosi/spi_miso pins that drive the board flash. A single-word fetch buffer returns repeated fetches of the same word with zero wait states.

Parameters:
CLK_DIV, 1, SCK half-period in clk_i cycles (1..255); SCK = clk_i/(2*CLK_DIV)
CS_GAP, 2, minimum spi_cs high time in clk_i cycles between transactions (>=1)
FLASH_OFFSET, 24'h000000, byte offset added to haddr_i[23:0] to form the flash address

Ports:
clk_i  in  1  system clock (clk_soc domain)
rst_i  in  1  synchronous reset, active-high
flush_i  in  1  invalidate fetch buffer (single-cycle pulse)
ahbl_hsel_i  in  1  slave select
ahbl_haddr_i  in  32  address
ahbl_htrans_i  in  2  transfer type
ahbl_hwrite_i  in  1  write flag
ahbl_hsize_i  in  3  transfer size (ignored; full word always fetched)
ahbl_hready_i  in  1  bus ready
ahbl_hwdata_i  in  32  write data (unused)
ahbl_hreadyout_o  out  1  slave ready
ahbl_hresp_o  out  1  0=OKAY, 1=ERROR
ahbl_hrdata_o  out  32  read data
spi_cs  out  1  flash chip select, active-low
spi_clk  out  1  SCK, mode 0
spi_mosi  out  1  serial data to flash
spi_miso  in  1  serial data from flash

Behaviour:
- Reset: hreadyout_o=1, hresp_o=0, hrdata_o=0, spi_cs=1, spi_clk=0, spi_mosi=0, buffer invalid, state IDLE. Reset mid-transaction aborts immediately with the same values; no partial data is retained.
- Address phase accepted when hsel_i & hready_i & htrans_i[1]. IDLE/BUSY transfers produce an OKAY zero-wait response.
- Write accepted: two-cycle ERROR (ERR1: hreadyout=0,hresp=1; ERR2: hreadyout=1,hresp=1); no SPI activity.
- Read hit (buffer valid, buffer tag == haddr_i[23:2]): data phase N+1 with hreadyout=1, hrdata=buffer, no SPI activity.
- Read miss: flash addr = (haddr_i[23:0] & ~3) + FLASH_OFFSET, mod 2^24.
- States: IDLE -> GAP (only if the spi_cs-high count is < CS_GAP) -> SHIFT -> DONE -> IDLE; IDLE -> ERR1 -> ERR2 -> IDLE.
- SHIFT: spi_cs=0. Sends 32 bits {8'h03, addr[23:0]} MSB first, then clocks 32 read bits.
- Each bit is CLK_DIV cycles with SCK low, then CLK_DIV cycles with SCK high.
- spi_mosi changes only while SCK is low. spi_miso is sampled on the clk_i edge that drives SCK high.
- spi_mosi=0 during the data bits.
- Read byte order is little-endian: first byte received -> hrdata[7:0], fourth -> hrdata[31:24].
- DONE (single cycle): spi_cs=1, spi_clk=0, hreadyout=1, hrdata=assembled word, buffer loaded with tag and valid set.
- Miss latency with no gap: hreadyout_o low from N+1 for exactly 64*2*CLK_DIV cycles; high in the following cycle.
- A new address phase may be accepted in DONE, ERR2, or zero-wait cycles. If that new phase is a miss and the spi_cs-high count is < CS_GAP, it waits in GAP with hreadyout=0 until the gap is met.
- hrdata_o holds its last value outside DONE/hit cycles.
- flush_i clears valid at the next edge. If flush_i coincides with DONE, flush wins (data is returned, buffer stays invalid). Flush during SHIFT does not abort the transfer.
- hresp_o=0 in all states except ERR1/ERR2.

Decomposition:
- Shared package spi_flash_pkg holds: CMD_READ=8'h03; HTRANS encodings IDLE/BUSY/NONSEQ/SEQ; the state enum {IDLE, GAP, SHIFT, DONE, ERR1, ERR2}.
- Sub-module spi_bit_engine: SCK divider, 64-bit shift counter, MOSI shifter, MISO capture; start/busy/done handshake.
- The top level keeps the AHB FSM and the fetch buffer.

Test Plan:
- Reset then read 0x00000100, flash bytes [0x100..0x103]=13,00,00,00 -> spi_mosi stream 0x03,0x00,0x01,0x00; hrdata=0x00000013, hresp=0; hreadyout low exactly 128 cycles (CLK_DIV=1).
- Back-to-back reads 0x104 then 0x104 -> first takes 128 wait cycles; second has zero wait states, same data, spi_cs stays high.
- NONSEQ read 0x200 accepted in the DONE cycle of a previous miss (CS_GAP=2) -> spi_cs high for 2 cycles before reasserting; data correct.
- Write to 0x0 -> hresp=1 for two cycles, hreadyout 0 then 1; spi_cs never asserted.
- flush_i pulse then re-read 0x104 -> full SPI transaction reissued. rst_i asserted at SPI bit 20 -> next cycle spi_cs=1, spi_clk=0, hreadyout=1; the next read to 0x104 misses.
- CLK_DIV=3, FLASH_OFFSET=24'h100000, read 0x8 -> SCK period 6 cycles; address bytes 0x10,0x00,0x08; 384 wait cycles.
